srlatch_driver: RTL and testbench
=================================

# srlatch_driver

Synchronous controller that drives the set/reset inputs of a downstream SR latch from one-cycle command requests. It produces clean, fixed-width `s`/`r` pulses and guarantees `s` and `r` are never high together. It enforces a dead time between commands and checks the latch's `q`/`qb` feedback after each pulse. It sits between control logic and an `srlatch` instance, on the driving end of the latch's s/r interface.

## Interface
- `PULSE_W`, 4: cycles `s` or `r` is held high per command; legal range 1–15.
- `DEAD_T`, 2: cycles `s`=`r`=0 after the check cycle before the next command can be accepted; legal range 1–15.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `set_req`  input  1  request a set command; sampled only in IDLE.
- `clr_req`  input  1  request a reset (clear) command; sampled only in IDLE.
- `q_fb`  input  1  latch `q` feedback.
- `qb_fb`  input  1  latch `qb` feedback.
- `s`  output  1  latch set drive.
- `r`  output  1  latch reset drive.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse marking command completion.
- `err`  output  1  one-cycle pulse, qualified with `done`, when feedback mismatched.
- `rej`  output  1  one-cycle pulse when `set_req` and `clr_req` are both high in IDLE.

## Operation
- State register with four states: IDLE, DRIVE, CHECK, DEAD. Command register `cmd` holds SET or CLR. One down-counter is sized for max(`PULSE_W`, `DEAD_T`), 4 bits.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- IDLE:
  - `set_req`=1, `clr_req`=0: `cmd`=SET, counter=`PULSE_W`-1, go to DRIVE.
  - `clr_req`=1, `set_req`=0: `cmd`=CLR, same counter load, go to DRIVE.
  - Both high: stay in IDLE and pulse `rej` for the next cycle.
  - Neither high: stay in IDLE.
- DRIVE:
  - `s` = (`cmd`==SET); `r` = (`cmd`==CLR).
  - Counter decrements each cycle; at 0, go to CHECK.
  - On the DRIVE→CHECK edge, sample `q_fb`/`qb_fb` into a registered mismatch flag. Mismatch means:
    - SET expects `q_fb`=1, `qb_fb`=0.
    - CLR expects `q_fb`=0, `qb_fb`=1.
    - `q_fb`==`qb_fb` is always a mismatch.
- CHECK: exactly one cycle.
  - `s`=`r`=0.
  - `done`=1 and `err`=mismatch flag.
  - Counter loads `DEAD_T`-1; go to DEAD.
- DEAD: `s`=`r`=0; counter decrements; at 0, go to IDLE.
- Requests arriving in DRIVE, CHECK or DEAD are ignored, not queued. A request still high on return to IDLE is accepted normally.
- Invariant: `s`&`r` is 0 in every cycle, including during and immediately after reset.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, counter=0, `cmd`=SET, mismatch=0. Outputs `s`, `r`, `busy`, `done`, `err`, `rej` all go to 0 without waiting for a clock edge.
- Reset asserted mid-DRIVE: `s`/`r` drop immediately and no `done` is produced.
- After `rst_n` deasserts, the first rising edge may accept a request.
- Request accepted at edge E0:
  - `s`/`r` high for cycles 1..`PULSE_W`.
  - `done`/`err` high in cycle `PULSE_W`+1.
  - DEAD occupies cycles `PULSE_W`+2..`PULSE_W`+1+`DEAD_T`.
  - `busy` is high for `PULSE_W`+1+`DEAD_T` cycles.
  - Earliest next acceptance is at the edge ending the last DEAD cycle.
- `rej` is high the cycle after the conflicting sample; `busy` stays 0.
- `done` and `err` are never asserted outside CHECK.
- Feedback is sampled once, at the end of the last DRIVE cycle. Feedback changes at any other time have no effect.

## Test plan
All scenarios use `PULSE_W`=4 and `DEAD_T`=2; the bench models a behavioural SR latch on `s`/`r` unless stated.
- Reset: hold `rst_n`=0 while toggling requests -> `s`=`r`=`busy`=`done`=`err`=`rej`=0 throughout; assert `rst_n` mid-clock and check the outputs clear before the next edge.
- Set: one-cycle `set_req` from q=0 -> `s`=1 for cycles 1–4, `r`=0; `done`=1, `err`=0 in cycle 5; `busy`=1 for cycles 1–7; `q_fb`=1 afterwards.
- Clear with stuck feedback: force `q_fb`=1, `qb_fb`=0, then one-cycle `clr_req` -> `r`=1 for cycles 1–4; `done`=1 and `err`=1 in cycle 5. Repeat with `q_fb`=`qb_fb`=1 -> `err`=1.
- Conflict: `set_req`=`clr_req`=1 for one cycle in IDLE -> `rej`=1 for one cycle; `s`=`r`=0; `busy` stays 0.
- Back-to-back: `set_req` held high for 20 cycles -> second SET pulse starts in cycle 8; `clr_req` pulsed in cycle 3 is ignored; `s`&`r`=0 in every cycle.
- Reset mid-operation: assert `rst_n`=0 in cycle 2 of DRIVE -> `s` falls asynchronously; after release, IDLE with no `done`; a new `clr_req` then completes normally with `err`=0.

Source files
------------

// File: rtl/srlatch_driver_if.sv
// Command/feedback bundle between control logic and the SR-latch driver.
// The driver sits on the slave side; the requester (and latch feedback) on the master side.
interface srlatch_driver_if;
  logic set_req;
  logic clr_req;
  logic q_fb;
  logic qb_fb;
  logic s;
  logic r;
  logic busy;
  logic done;
  logic err;
  logic rej;

  modport master (
    output set_req, clr_req, q_fb, qb_fb,
    input  s, r, busy, done, err, rej
  );

  modport slave (
    input  set_req, clr_req, q_fb, qb_fb,
    output s, r, busy, done, err, rej
  );
endinterface

// File: rtl/srlatch_driver.sv
// Drives s/r of a downstream SR latch with fixed-width pulses, enforces a
// dead time between commands and verifies q/qb feedback after each pulse.
module srlatch_driver #(
  parameter int unsigned PULSE_W = 4,  // 1..15
  parameter int unsigned DEAD_T  = 2   // 1..15
) (
  input logic             clk,
  input logic             rst_n,
  srlatch_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DEAD  = 2'd3
  } state_e;

  typedef enum logic {
    CMD_SET = 1'b0,
    CMD_CLR = 1'b1
  } cmd_e;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
  localparam logic [3:0] DEAD_LD  = 4'(DEAD_T - 1);

  state_e     state_q, state_d;
  cmd_e       cmd_q,   cmd_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       mis_q,   mis_d;
  logic       rej_q,   rej_d;

  logic       fb_ok;
  logic       accept_window;

  // Feedback is correct only when q/qb are complementary and match the command.
  assign fb_ok = (cmd_q == CMD_SET) ? ( bus.q_fb && !bus.qb_fb)
                                    : (!bus.q_fb &&  bus.qb_fb);

  // A new command may be taken in IDLE or on the edge that ends the last DEAD cycle.
  assign accept_window = (state_q == IDLE) || ((state_q == DEAD) && (cnt_q == 4'd0));

  // State register: all control state clears asynchronously so s/r drop at once.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= CMD_SET;
      cnt_q   <= 4'd0;
      mis_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      rej_q   <= rej_d;
    end
  end

  // Next-state logic: sequencing, counter, command capture and feedback sampling.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    rej_d   = 1'b0;

    unique case (state_q)
      DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = CHECK;
          mis_d   = !fb_ok;
        end
      end
      CHECK: begin
        cnt_d   = DEAD_LD;
        state_d = DEAD;
      end
      IDLE, DEAD: begin
        if (!accept_window) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (bus.set_req && !bus.clr_req) begin
            cmd_d   = CMD_SET;
            cnt_d   = PULSE_LD;
            state_d = DRIVE;
          end else if (bus.clr_req && !bus.set_req) begin
            cmd_d   = CMD_CLR;
            cnt_d   = PULSE_LD;
            state_d = DRIVE;
          end else if (bus.set_req && bus.clr_req) begin
            rej_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded only from registered state; s and r are exclusive by construction.
  always_comb begin
    bus.s    = (state_q == DRIVE) && (cmd_q == CMD_SET);
    bus.r    = (state_q == DRIVE) && (cmd_q == CMD_CLR);
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == CHECK);
    bus.err  = (state_q == CHECK) && mis_q;
    bus.rej  = rej_q;
  end

endmodule

// File: tb/tb_srlatch_driver.sv
// Bench for srlatch_driver: behavioural SR latch on s/r with optional forced
// feedback; expected completion results are queued at request time and
// popped when done is observed.
module tb_srlatch_driver;

  localparam int PW = 4;
  localparam int DT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  srlatch_driver_if bif ();

  // Behavioural latch plus override for stuck-feedback scenarios.
  logic q_lat  = 1'b0;
  logic ovr_en = 1'b0;
  logic ovr_q  = 1'b0;
  logic ovr_qb = 1'b0;

  bit exp_err_q[$];

  srlatch_driver #(.PULSE_W(PW), .DEAD_T(DT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bif.s)      q_lat <= 1'b1;
    else if (bif.r) q_lat <= 1'b0;
  end

  assign bif.q_fb  = ovr_en ? ovr_q  : q_lat;
  assign bif.qb_fb = ovr_en ? ovr_qb : ~q_lat;

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      bif.set_req = i[0];
      bif.clr_req = i[1];
      @(negedge clk);
      checks++;
      if ({bif.s, bif.r, bif.busy, bif.done, bif.err, bif.rej} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: s,r,busy,done,err,rej=%b want 000000", i,
                 {bif.s, bif.r, bif.busy, bif.done, bif.err, bif.rej});
      end
      @(posedge clk); #1;
    end
    bif.set_req = 1'b0;
    bif.clr_req = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b want 0", bif.busy);
    end
  endtask

  // Issue one command from IDLE and check cycles 1..PW+DT+2 against spec timing.
  task automatic run_cmd(input bit is_set, input bit exp_err, input string nm);
    bit e_s, e_r, e_busy, e_done, e;
    exp_err_q.push_back(exp_err);
    bif.set_req = is_set;
    bif.clr_req = !is_set;
    @(posedge clk); #1;
    bif.set_req = 1'b0;
    bif.clr_req = 1'b0;
    for (int c = 1; c <= PW + DT + 2; c++) begin
      @(negedge clk);
      e_s    = is_set  && (c <= PW);
      e_r    = !is_set && (c <= PW);
      e_done = (c == PW + 1);
      e_busy = (c <= PW + 1 + DT);
      checks++;
      if ({bif.s, bif.r, bif.busy, bif.done} !== {e_s, e_r, e_busy, e_done}) begin
        errors++;
        $display("FAIL %s cyc%0d: s,r,busy,done=%b want %b", nm, c,
                 {bif.s, bif.r, bif.busy, bif.done}, {e_s, e_r, e_busy, e_done});
      end
      if (bif.done === 1'b1 && exp_err_q.size() > 0) begin
        e = exp_err_q.pop_front();
        checks++;
        if (bif.err !== e) begin
          errors++;
          $display("FAIL %s_err: err=%b want %b", nm, bif.err, e);
        end
      end else if (bif.err !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s_err_stray cyc%0d: err=%b want 0", nm, c, bif.err);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_err_q.size() != 0) begin
      errors++;
      $display("FAIL %s_no_done: pending=%0d want 0", nm, exp_err_q.size());
      exp_err_q.delete();
    end
  endtask

  task automatic test_set();
    run_cmd(1'b1, 1'b0, "set");
    checks++;
    if (bif.q_fb !== 1'b1) begin
      errors++;
      $display("FAIL set_q_fb: q_fb=%b want 1", bif.q_fb);
    end
  endtask

  task automatic test_clear_stuck();
    ovr_en = 1'b1; ovr_q = 1'b1; ovr_qb = 1'b0;
    run_cmd(1'b0, 1'b1, "clr_stuck10");
    ovr_q = 1'b1; ovr_qb = 1'b1;
    run_cmd(1'b0, 1'b1, "clr_stuck11");
    ovr_en = 1'b0;
  endtask

  task automatic test_conflict();
    bif.set_req = 1'b1;
    bif.clr_req = 1'b1;
    @(posedge clk); #1;
    bif.set_req = 1'b0;
    bif.clr_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bif.rej, bif.s, bif.r, bif.busy} !== {(c == 1), 3'b000}) begin
        errors++;
        $display("FAIL conflict cyc%0d: rej,s,r,busy=%b want %b", c,
                 {bif.rej, bif.s, bif.r, bif.busy}, {(c == 1), 3'b000});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    bit e_s, e_done, e;
    for (int k = 0; k < 3; k++) exp_err_q.push_back(1'b0);
    bif.set_req = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(posedge clk); #1;
      bif.clr_req = (c == 3);
      if (c == 20) bif.set_req = 1'b0;
      @(negedge clk);
      e_s    = (c >= 1 && c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18);
      e_done = (c == 5) || (c == 12) || (c == 19);
      checks++;
      if ({bif.s, bif.r, bif.done, bif.s & bif.r} !== {e_s, 1'b0, e_done, 1'b0}) begin
        errors++;
        $display("FAIL b2b cyc%0d: s,r,done,s&r=%b want %b", c,
                 {bif.s, bif.r, bif.done, bif.s & bif.r}, {e_s, 1'b0, e_done, 1'b0});
      end
      if (bif.done === 1'b1 && exp_err_q.size() > 0) begin
        e = exp_err_q.pop_front();
        checks++;
        if (bif.err !== e) begin
          errors++;
          $display("FAIL b2b_err cyc%0d: err=%b want %b", c, bif.err, e);
        end
      end
    end
    checks++;
    if (exp_err_q.size() != 0 || bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: pending=%0d busy=%b want 0 0", exp_err_q.size(), bif.busy);
      exp_err_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    bif.set_req = 1'b1;
    @(posedge clk); #1;
    bif.set_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bif.s !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: s=%b want 1", bif.s);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.s, bif.r, bif.busy, bif.done, bif.err, bif.rej} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_async: s,r,busy,done,err,rej=%b want 000000",
               {bif.s, bif.r, bif.busy, bif.done, bif.err, bif.rej});
    end
    #3 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bif.busy, bif.done, bif.s} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid_idle cyc%0d: busy,done,s=%b want 000", c,
                 {bif.busy, bif.done, bif.s});
      end
    end
    @(posedge clk); #1;
    run_cmd(1'b0, 1'b0, "clr_after_rst");
  endtask

  initial begin
    bif.set_req = 1'b0;
    bif.clr_req = 1'b0;
    test_reset();
    test_set();
    test_clear_stuck();
    test_conflict();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
